// File: rtl/fu_pkg.sv
// Shared definitions for the function unit and the multiply sequencer.
// Function-select codes are common to both blocks; the state encoding is sequencer-private.
package fu_pkg;

  localparam int unsigned FsCodeW = 4;

  localparam logic [FsCodeW-1:0] FS_PASSA = 4'h0;
  localparam logic [FsCodeW-1:0] FS_ADD   = 4'h2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } mult_state_e;

endpackage

// File: rtl/fu_mult_skip_shift.sv
// Barrel shifter that collapses the trailing PASS steps of a multiply into one cycle.
// Present only when FU_MULT_ZERO_SKIP_EN is defined.
`ifdef FU_MULT_ZERO_SKIP_EN
module fu_mult_skip_shift #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic [2*WIDTH-1:0] din,
  input  logic [CNT_W-1:0]   cnt,
  output logic [2*WIDTH-1:0] dout
);

  assign dout = din >> cnt;

endmodule
`endif

// File: rtl/fu_mult_sequencer.sv
// Shift-and-add unsigned multiplier that borrows the CPU function unit as its adder.
// Optional FU_MULT_ZERO_SKIP_EN: finish early once the remaining multiplier bits are all zero.
module fu_mult_sequencer
  import fu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned FS_W  = 4,
  parameter int unsigned SH_W  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 prod_z,
  output logic [WIDTH-1:0]     fu_a,
  output logic [WIDTH-1:0]     fu_b,
  output logic [FS_W-1:0]      fu_fs,
  output logic [SH_W-1:0]      fu_sh,
  input  logic [WIDTH-1:0]     fu_f,
  input  logic                 fu_c
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [FS_W-1:0] FsPassA = FS_W'(FS_PASSA);
  localparam logic [FS_W-1:0] FsAdd   = FS_W'(FS_ADD);

  mult_state_e          state_q, state_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 prod_z_q, prod_z_d;

  logic                 is_add, cy;
  logic [WIDTH-1:0]     step_hi, step_lo;
  logic [CntW-1:0]      step_cnt;

  // One shift-and-add step using the function unit's result; carry only counts on ADD.
  always_comb begin
    is_add   = (state_q == StRun) && lo_q[0];
    cy       = is_add & fu_c;
    step_hi  = {cy, fu_f[WIDTH-1:1]};
    step_lo  = {fu_f[0], lo_q[WIDTH-1:1]};
    step_cnt = cnt_q - CntW'(1);
  end

`ifdef FU_MULT_ZERO_SKIP_EN
  logic               rem_zero;
  logic [2*WIDTH-1:0] skip_prod;

  // After this step the low step_cnt bits of lo are the unconsumed multiplier bits.
  always_comb begin
    rem_zero = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if ((i < int'(step_cnt)) && step_lo[i]) rem_zero = 1'b0;
    end
  end

  fu_mult_skip_shift #(
    .WIDTH (WIDTH),
    .CNT_W (CntW)
  ) u_skip_shift (
    .din  ({step_hi, step_lo}),
    .cnt  (step_cnt),
    .dout (skip_prod)
  );
`endif

  // Next-state, datapath update and function-unit drive.
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    prod_z_d  = prod_z_q;
    fu_a      = '0;
    fu_b      = '0;
    fu_fs     = FsPassA;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          hi_d    = '0;
          lo_d    = b_in;
          mcand_d = a_in;
          cnt_d   = CntW'(WIDTH);
          state_d = StRun;
        end
      end
      StRun: begin
        fu_a  = hi_q;
        fu_b  = mcand_q;
        fu_fs = is_add ? FsAdd : FsPassA;
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = step_cnt;
        // Product is captured on entry to DONE so it is valid alongside the done pulse.
        if (cnt_q == CntW'(1)) begin
          state_d   = StDone;
          product_d = {step_hi, step_lo};
          prod_z_d  = ({step_hi, step_lo} == '0);
        end
`ifdef FU_MULT_ZERO_SKIP_EN
        else if (rem_zero) begin
          {hi_d, lo_d} = skip_prod;
          cnt_d        = '0;
          state_d      = StDone;
          product_d    = skip_prod;
          prod_z_d     = (skip_prod == '0);
        end
`endif
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      prod_z_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      prod_z_q  <= prod_z_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign product = product_q;
  assign prod_z  = prod_z_q;
  assign fu_sh   = '0;

endmodule
